// File: rtl/td4_input_debounce.sv
// Switch conditioner for the TD4 cpu input port: 2-flop synchroniser,
// per-bit debounce counters, registered value and a one-cycle change strobe.
module td4_input_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] inp,
    output logic             inp_changed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] inp_nxt;
    logic             changed_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // Each bit runs its own counter; a matching sample drops any partial count.
    always_comb begin
        inp_nxt = inp;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = cnt[i];
            if (sync2[i] == inp[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                inp_nxt[i] = sync2[i];
                cnt_nxt[i] = '0;
            end else begin
                cnt_nxt[i] = cnt[i] + 1'b1;
            end
        end
        changed_nxt = (inp_nxt != inp);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inp         <= '0;
            inp_changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            inp         <= inp_nxt;
            inp_changed <= changed_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule
